ascon_ctrl: RTL and testbench

ASCON_CTRL -- requirements
Module: ascon_ctrl

---
 rtl/ascon_ctrl_if.sv | 38 +++
 rtl/ascon_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ascon_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ascon_ctrl_if.sv
// Control-plane bundle between the Ascon initiator, the Ascon controller and the
// permutation datapath.
interface ascon_ctrl_if;
    logic       init_i;
    logic       associate_data_i;
    logic       finalisation_i;
    logic       data_valid_i;

    logic       end_initialisation_o;
    logic       end_associate_o;
    logic       cipher_valid_o;
    logic       end_cipher_o;
    logic       end_tag_o;

    logic       load_state_o;
    logic       en_state_o;
    logic [3:0] round_o;
    logic       xor_data_o;
    logic       xor_dom_sep_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       en_cipher_o;
    logic       en_tag_o;

    modport slave (
        input  init_i, associate_data_i, finalisation_i, data_valid_i,
        output end_initialisation_o, end_associate_o, cipher_valid_o, end_cipher_o,
               end_tag_o, load_state_o, en_state_o, round_o, xor_data_o,
               xor_dom_sep_o, xor_key_begin_o, xor_key_end_o, en_cipher_o, en_tag_o
    );

    modport master (
        output init_i, associate_data_i, finalisation_i, data_valid_i,
        input  end_initialisation_o, end_associate_o, cipher_valid_o, end_cipher_o,
               end_tag_o, load_state_o, en_state_o, round_o, xor_data_o,
               xor_dom_sep_o, xor_key_begin_o, xor_key_end_o, en_cipher_o, en_tag_o
    );
endinterface

// File: rtl/ascon_ctrl.sv
// Ascon AEAD sequencer: walks init, associated data, plaintext and finalisation
// phases and drives the permutation datapath selects and round-constant index.
module ascon_ctrl #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    ascon_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, INIT_LOAD, INIT_RND, WAIT_AD, AD_XOR, AD_RND,
        WAIT_PT, PT_XOR, PT_RND, FIN_XOR, FIN_RND
    } state_e;

    localparam logic [3:0] START_A    = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] START_B    = 4'(12 - NB_ROUNDS_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       init_armed_q, init_armed_d;
    logic       data_armed_q, data_armed_d;
    logic       dom_sep_q, dom_sep_d;
    logic       end_init_q, end_init_d;
    logic       end_assoc_q, end_assoc_d;
    logic       cipher_valid_q, cipher_valid_d;
    logic       end_cipher_q, end_cipher_d;
    logic       end_tag_q, end_tag_d;

    logic       last_round;
    logic       init_go;
    logic       data_go;
    logic       accept_init;
    logic       accept_data;

    function automatic logic is_round(input state_e s);
        return (s == INIT_RND) || (s == AD_RND) || (s == PT_RND) || (s == FIN_RND);
    endfunction

    assign last_round = (round_q == LAST_ROUND);
    assign init_go    = init_armed_q && bus.init_i;
    assign data_go    = data_armed_q && bus.data_valid_i;

    // NOTE: every signal driven here gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        dom_sep_d   = dom_sep_q;
        accept_init = 1'b0;
        accept_data = 1'b0;

        unique case (state_q)
            IDLE: if (init_go) begin
                state_d     = INIT_LOAD;
                accept_init = 1'b1;
            end
            INIT_LOAD: state_d = INIT_RND;
            INIT_RND:  if (last_round) state_d = WAIT_AD;
            WAIT_AD, WAIT_PT: if (data_go) begin
                // Finalisation wins over associated data; AD after plaintext is dropped.
                if (bus.finalisation_i) begin
                    state_d     = FIN_XOR;
                    accept_data = 1'b1;
                end else if (!bus.associate_data_i) begin
                    state_d     = PT_XOR;
                    accept_data = 1'b1;
                end else if (state_q == WAIT_AD) begin
                    state_d     = AD_XOR;
                    accept_data = 1'b1;
                end
                if (accept_data) dom_sep_d = (state_q == WAIT_AD);
            end
            AD_XOR:  state_d = AD_RND;
            AD_RND:  if (last_round) state_d = WAIT_AD;
            PT_XOR:  state_d = PT_RND;
            PT_RND:  if (last_round) state_d = WAIT_PT;
            FIN_XOR: state_d = FIN_RND;
            FIN_RND: if (last_round) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A request re-arms only after its input has been seen low.
        init_armed_d = accept_init ? 1'b0 : (!bus.init_i ? 1'b1 : init_armed_q);
        data_armed_d = accept_data ? 1'b0 : (!bus.data_valid_i ? 1'b1 : data_armed_q);

        round_d = 4'd0;
        if (is_round(state_d)) begin
            if (state_d == state_q)
                round_d = round_q + 4'd1;
            else if (state_d == INIT_RND || state_d == FIN_RND)
                round_d = START_A;
            else
                round_d = START_B;
        end

        end_init_d     = (state_q == INIT_RND) && last_round;
        end_assoc_d    = (state_q == AD_RND)   && last_round;
        end_cipher_d   = (state_q == PT_RND)   && last_round;
        end_tag_d      = (state_q == FIN_RND)  && last_round;
        cipher_valid_d = (state_q == PT_XOR) || (state_q == FIN_XOR);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= IDLE;
            round_q        <= 4'd0;
            // Armed at reset so an init_i already high is taken on the first edge.
            init_armed_q   <= 1'b1;
            data_armed_q   <= 1'b1;
            dom_sep_q      <= 1'b0;
            end_init_q     <= 1'b0;
            end_assoc_q    <= 1'b0;
            cipher_valid_q <= 1'b0;
            end_cipher_q   <= 1'b0;
            end_tag_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            init_armed_q   <= init_armed_d;
            data_armed_q   <= data_armed_d;
            dom_sep_q      <= dom_sep_d;
            end_init_q     <= end_init_d;
            end_assoc_q    <= end_assoc_d;
            cipher_valid_q <= cipher_valid_d;
            end_cipher_q   <= end_cipher_d;
            end_tag_q      <= end_tag_d;
        end
    end

    always_comb begin
        bus.load_state_o    = 1'b0;
        bus.en_state_o      = 1'b0;
        bus.round_o         = is_round(state_q) ? round_q : 4'd0;
        bus.xor_data_o      = 1'b0;
        bus.xor_dom_sep_o   = 1'b0;
        bus.xor_key_begin_o = 1'b0;
        bus.xor_key_end_o   = 1'b0;
        bus.en_cipher_o     = 1'b0;
        bus.en_tag_o        = 1'b0;

        unique case (state_q)
            INIT_LOAD: begin
                bus.load_state_o = 1'b1;
                bus.en_state_o   = 1'b1;
            end
            INIT_RND: begin
                bus.en_state_o    = 1'b1;
                bus.xor_key_end_o = last_round;
            end
            AD_XOR: begin
                bus.xor_data_o = 1'b1;
                bus.en_state_o = 1'b1;
            end
            PT_XOR: begin
                bus.xor_data_o    = 1'b1;
                bus.en_cipher_o   = 1'b1;
                bus.en_state_o    = 1'b1;
                bus.xor_dom_sep_o = dom_sep_q;
            end
            FIN_XOR: begin
                bus.xor_data_o      = 1'b1;
                bus.en_cipher_o     = 1'b1;
                bus.xor_key_begin_o = 1'b1;
                bus.en_state_o      = 1'b1;
                bus.xor_dom_sep_o   = dom_sep_q;
            end
            AD_RND, PT_RND: bus.en_state_o = 1'b1;
            FIN_RND: begin
                bus.en_state_o    = 1'b1;
                bus.xor_key_end_o = last_round;
                bus.en_tag_o      = last_round;
            end
            default: ;
        endcase
    end

    assign bus.end_initialisation_o = end_init_q;
    assign bus.end_associate_o      = end_assoc_q;
    assign bus.cipher_valid_o       = cipher_valid_q;
    assign bus.end_cipher_o         = end_cipher_q;
    assign bus.end_tag_o            = end_tag_q;

endmodule

// File: tb/tb_ascon_ctrl.sv
// Directed bench for ascon_ctrl: cycle-by-cycle comparison of every output against
// a hand-written timing table for each phase.
module tb_ascon_ctrl;

    typedef enum int {OP_INIT, OP_AD, OP_PT, OP_FIN} op_e;

    typedef struct packed {
        logic       end_init;
        logic       end_assoc;
        logic       cipher_valid;
        logic       end_cipher;
        logic       end_tag;
        logic       load;
        logic       en_state;
        logic [3:0] round;
        logic       xor_data;
        logic       dom_sep;
        logic       key_begin;
        logic       key_end;
        logic       en_cipher;
        logic       en_tag;
    } obs_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    ascon_ctrl_if bus ();

    ascon_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.end_init     = bus.end_initialisation_o;
        o.end_assoc    = bus.end_associate_o;
        o.cipher_valid = bus.cipher_valid_o;
        o.end_cipher   = bus.end_cipher_o;
        o.end_tag      = bus.end_tag_o;
        o.load         = bus.load_state_o;
        o.en_state     = bus.en_state_o;
        o.round        = bus.round_o;
        o.xor_data     = bus.xor_data_o;
        o.dom_sep      = bus.xor_dom_sep_o;
        o.key_begin    = bus.xor_key_begin_o;
        o.key_end      = bus.xor_key_end_o;
        o.en_cipher    = bus.en_cipher_o;
        o.en_tag       = bus.en_tag_o;
        return o;
    endfunction

    // Expected outputs in cycle k after the accepting edge (k = 1 is the first cycle).
    function automatic obs_t expect_at(input op_e op, input int k, input bit dom);
        obs_t e = '0;
        case (op)
            OP_INIT: begin
                e.load     = (k == 1);
                e.en_state = (k >= 1 && k <= 13);
                e.round    = (k >= 2 && k <= 13) ? 4'(k - 2) : 4'd0;
                e.key_end  = (k == 13);
                e.end_init = (k == 14);
            end
            OP_AD: begin
                e.xor_data  = (k == 1);
                e.en_state  = (k >= 1 && k <= 7);
                e.round     = (k >= 2 && k <= 7) ? 4'(k + 4) : 4'd0;
                e.end_assoc = (k == 8);
            end
            OP_PT: begin
                e.xor_data     = (k == 1);
                e.en_cipher    = (k == 1);
                e.dom_sep      = (k == 1) && dom;
                e.en_state     = (k >= 1 && k <= 7);
                e.round        = (k >= 2 && k <= 7) ? 4'(k + 4) : 4'd0;
                e.cipher_valid = (k == 2);
                e.end_cipher   = (k == 8);
            end
            OP_FIN: begin
                e.xor_data     = (k == 1);
                e.en_cipher    = (k == 1);
                e.key_begin    = (k == 1);
                e.dom_sep      = (k == 1) && dom;
                e.en_state     = (k >= 1 && k <= 13);
                e.round        = (k >= 2 && k <= 13) ? 4'(k - 2) : 4'd0;
                e.cipher_valid = (k == 2);
                e.key_end      = (k == 13);
                e.en_tag       = (k == 13);
                e.end_tag      = (k == 14);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Caller has set up the request inputs; the next rising edge is the accepting edge.
    // Requests are dropped in cycle 1 unless hold is set; pulse_k injects a one-cycle
    // data_valid_i pulse mid-operation.
    task automatic run_op(input op_e op, input string name, input bit dom,
                          input bit hold, input int pulse_k);
        int last = (op == OP_INIT || op == OP_FIN) ? 14 : 8;
        @(posedge clk);
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", name, k), 32'(sample()), 32'(expect_at(op, k, dom)));
            if (k == 1 && !hold) begin
                bus.init_i       = 1'b0;
                bus.data_valid_i = 1'b0;
            end
            if (k == pulse_k)          bus.data_valid_i = 1'b1;
            else if (k == pulse_k + 1) bus.data_valid_i = 1'b0;
        end
    endtask

    task automatic quiet(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s_%0d", name, k), 32'(sample()), 32'd0);
        end
    endtask

    task automatic set_req(input bit init, input bit dv, input bit ad, input bit fin);
        bus.init_i           = init;
        bus.data_valid_i     = dv;
        bus.associate_data_i = ad;
        bus.finalisation_i   = fin;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t o;
        rst_n = 1'b0;
        set_req(0, 0, 0, 0);
        quiet("reset", 3);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("idle", 2);

        // Session 1: init, one AD block, two plaintext blocks, finalisation.
        @(negedge clk); set_req(1, 0, 0, 0);
        run_op(OP_INIT, "init1", 0, 0, 0);
        @(negedge clk); set_req(0, 1, 1, 0);
        run_op(OP_AD, "ad1", 0, 0, 0);
        @(negedge clk); set_req(0, 1, 0, 0);
        run_op(OP_PT, "pt1", 1, 0, 0);
        @(negedge clk); set_req(0, 1, 0, 0);
        run_op(OP_PT, "pt2", 0, 0, 4);

        // AD after plaintext and init outside IDLE are both ignored.
        @(negedge clk); set_req(1, 1, 1, 0);
        quiet("pt_ad_ignored", 4);
        set_req(0, 0, 0, 0);
        quiet("pt_wait", 1);

        // Finalisation held high: one tag, then no re-acceptance in IDLE.
        @(negedge clk); set_req(0, 1, 0, 1);
        run_op(OP_FIN, "fin1", 0, 1, 0);
        quiet("fin_hold", 3);
        set_req(0, 0, 0, 0);
        quiet("idle2", 1);

        // Session 2: finalisation straight from WAIT_AD, overriding associate_data_i.
        @(negedge clk); set_req(1, 0, 0, 0);
        run_op(OP_INIT, "init2", 0, 0, 0);
        @(negedge clk); set_req(0, 1, 1, 1);
        run_op(OP_FIN, "fin2", 1, 0, 0);

        // Reset during INIT_RND round 5, then init taken on the first edge after release.
        @(negedge clk); set_req(1, 0, 0, 0);
        @(posedge clk);
        repeat (7) @(negedge clk);
        bus.init_i = 1'b0;
        o = sample();
        check("mid_round", 32'(o.round), 32'd5);
        rst_n = 1'b0;
        #1;
        check("reset_async", 32'(sample()), 32'd0);
        quiet("reset_hold", 3);
        bus.init_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_INIT, "init3", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
